// File: rtl/div_seq_ctrl_if.sv
// Handshake and data bundle between the control unit and the sequential divider.
interface div_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 sign_mode;
    logic [WIDTH-1:0]     RegA;
    logic [WIDTH-1:0]     RegB;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic [2*WIDTH-1:0]   Z;

    // Divider side
    modport slave (
        input  start, sign_mode, RegA, RegB,
        output busy, done, div_by_zero, Z
    );

    // Control-unit side
    modport master (
        output start, sign_mode, RegA, RegB,
        input  busy, done, div_by_zero, Z
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider: one shift/subtract/restore step per clock.
// Handshake is start/busy/done; result packs as Z = {remainder, quotient}.
module div_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           clr,
    div_seq_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_dvd, r_dvs;      // operands as captured on start
    logic                 r_sm;              // captured sign mode
    logic [WIDTH:0]       r_a;               // partial remainder, one guard bit
    logic [WIDTH-1:0]     r_q, r_m;
    logic [CW-1:0]        r_cnt;
    logic                 r_qneg, r_rneg, r_dz;
    logic                 r_busy, r_done, r_dzf;
    logic [2*WIDTH-1:0]   r_z;

    // Operand signs only matter in signed mode
    logic                 w_sa, w_sb;
    logic [WIDTH-1:0]     w_mag_a, w_mag_b;
    logic [WIDTH:0]       w_a_sh, w_diff;
    logic [WIDTH-1:0]     w_quo, w_rem;

    assign w_sa    = r_sm & r_dvd[WIDTH-1];
    assign w_sb    = r_sm & r_dvs[WIDTH-1];
    assign w_mag_a = w_sa ? -r_dvd : r_dvd;
    assign w_mag_b = w_sb ? -r_dvs : r_dvs;

    // Shift {A,Q} left one and trial-subtract the divisor
    assign w_a_sh  = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_diff  = w_a_sh - {1'b0, r_m};

    // Sign fix-up of the magnitude results
    assign w_quo   = r_qneg ? -r_q : r_q;
    assign w_rem   = r_rneg ? -r_a[WIDTH-1:0] : r_a[WIDTH-1:0];

    // Controller FSM with registered handshake outputs
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_sm    <= 1'b0;
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
            r_dz    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dzf   <= 1'b0;
            r_z     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dvd   <= bus.RegA;
                        r_dvs   <= bus.RegB;
                        r_sm    <= bus.sign_mode;
                        r_dzf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_qneg  <= w_sa ^ w_sb;
                    r_rneg  <= w_sa;
                    r_a     <= '0;
                    r_q     <= w_mag_a;
                    r_m     <= w_mag_b;
                    r_cnt   <= '0;
                    r_dz    <= (r_dvs == '0);
                    r_state <= (r_dvs == '0) ? S_FIX : S_ITER;
                end
                S_ITER: begin
                    // Negative trial result means the divisor did not fit: keep the shifted value
                    r_a   <= w_diff[WIDTH] ? w_a_sh : w_diff;
                    r_q   <= {r_q[WIDTH-2:0], ~w_diff[WIDTH]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_dz) begin
                        r_z   <= {r_dvd, {WIDTH{1'b1}}};
                        r_dzf <= 1'b1;
                    end else begin
                        r_z   <= {w_rem, w_quo};
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dzf;
    assign bus.Z           = r_z;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: latency, signed/unsigned results, div-by-zero,
// boundary operands, busy-time start filtering, mid-operation clear, back-to-back.
module tb_div_seq_ctrl;
    logic clk;
    logic clr;
    int   n_cmp = 0;
    int   n_err = 0;

    div_seq_ctrl_if #(.WIDTH(32)) bus ();

    div_seq_ctrl #(.WIDTH(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one operation and wait (bounded) for done; lat counts edges from the start edge
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sm,
                         output logic [63:0] z, output int lat, output logic dz,
                         output logic busy_ok);
        bus.start = 1'b1; bus.RegA = a; bus.RegB = b; bus.sign_mode = sm;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        busy_ok = (bus.busy === 1'b1) && (bus.done === 1'b0);
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done === 1'b1) busy_ok &= (bus.busy === 1'b0);
            else                   busy_ok &= (bus.busy === 1'b1);
        end
        z  = bus.Z;
        dz = bus.div_by_zero;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.start = 1'b0; bus.sign_mode = 1'b0; bus.RegA = '0; bus.RegB = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dz: got %b want 0", bus.div_by_zero); end
        n_cmp++; if (bus.Z !== 64'h0) begin n_err++; $display("FAIL reset_z: got %h want 0", bus.Z); end
        clr = 1'b0;
    endtask

    task automatic test_unsigned();
        logic [63:0] z; int lat; logic dz, bok;
        do_op(32'd100, 32'd7, 1'b0, z, lat, dz, bok);
        n_cmp++; if (z !== 64'h00000002_0000000E) begin n_err++; $display("FAIL u100_7_z: got %h want 000000020000000e", z); end
        n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL u100_7_latency: got %0d want 35", lat); end
        n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL u100_7_dz: got %b want 0", dz); end
        n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL u100_7_busy: got %b want 1", bok); end
        @(posedge clk); #1;
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL done_pulse: got %b want 0", bus.done); end
        n_cmp++; if (bus.Z !== 64'h00000002_0000000E) begin n_err++; $display("FAIL z_hold: got %h want 000000020000000e", bus.Z); end
    endtask

    task automatic test_signed();
        logic [63:0] z; int lat; logic dz, bok;
        do_op(32'hFFFFFF9C, 32'd7, 1'b1, z, lat, dz, bok);
        n_cmp++; if (z !== 64'hFFFFFFFE_FFFFFFF2) begin n_err++; $display("FAIL sm100_7_z: got %h want fffffffefffffff2", z); end
        n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL sm100_7_latency: got %0d want 35", lat); end
        do_op(32'd100, 32'hFFFFFFF9, 1'b1, z, lat, dz, bok);
        n_cmp++; if (z !== 64'h00000002_FFFFFFF2) begin n_err++; $display("FAIL s100_m7_z: got %h want 00000002fffffff2", z); end
        do_op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, z, lat, dz, bok);
        n_cmp++; if (z !== 64'hFFFFFFFE_0000000E) begin n_err++; $display("FAIL sm100_m7_z: got %h want fffffffe0000000e", z); end
    endtask

    task automatic test_div_zero();
        logic [63:0] z; int lat; logic dz, bok;
        @(posedge clk); #1;
        do_op(32'd5, 32'd0, 1'b0, z, lat, dz, bok);
        n_cmp++; if (z !== 64'h00000005_FFFFFFFF) begin n_err++; $display("FAIL dz_z: got %h want 00000005ffffffff", z); end
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL dz_latency: got %0d want 3", lat); end
        n_cmp++; if (dz !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b want 1", dz); end
        n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL dz_busy: got %b want 1", bok); end
        @(posedge clk); #1;
        n_cmp++; if (bus.div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_hold: got %b want 1", bus.div_by_zero); end
        bus.start = 1'b1; bus.RegA = 32'd9; bus.RegB = 32'd2; bus.sign_mode = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_cmp++; if (bus.div_by_zero !== 1'b0) begin n_err++; $display("FAIL dz_clear_on_start: got %b want 0", bus.div_by_zero); end
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (bus.Z !== 64'h00000001_00000004) begin n_err++; $display("FAIL after_dz_z: got %h want 0000000100000004", bus.Z); end
    endtask

    task automatic test_boundaries();
        logic [63:0] z; int lat; logic dz, bok;
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, z, lat, dz, bok);
        n_cmp++; if (z !== 64'h00000000_80000000) begin n_err++; $display("FAIL s_overflow_z: got %h want 0000000080000000", z); end
        n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL s_overflow_dz: got %b want 0", dz); end
        do_op(32'hFFFFFFFF, 32'd1, 1'b0, z, lat, dz, bok);
        n_cmp++; if (z !== 64'h00000000_FFFFFFFF) begin n_err++; $display("FAIL u_max_1_z: got %h want 00000000ffffffff", z); end
        do_op(32'd3, 32'hFFFFFFFF, 1'b0, z, lat, dz, bok);
        n_cmp++; if (z !== 64'h00000003_00000000) begin n_err++; $display("FAIL u_3_max_z: got %h want 0000000300000000", z); end
        do_op(32'h80000000, 32'd3, 1'b0, z, lat, dz, bok);
        n_cmp++; if (z !== 64'h00000002_2AAAAAAA) begin n_err++; $display("FAIL u_msb_3_z: got %h want 000000022aaaaaaa", z); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        bus.start = 1'b1; bus.RegA = 32'd1000; bus.RegB = 32'd10; bus.sign_mode = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.RegA = 32'd7; bus.RegB = 32'd3; bus.sign_mode = 1'b1;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            bus.start = (lat == 5) || (lat == 12);
        end
        bus.start = 1'b0;
        n_cmp++; if (bus.Z !== 64'h00000000_00000064) begin n_err++; $display("FAIL busy_ignore_z: got %h want 0000000000000064", bus.Z); end
        n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL busy_ignore_latency: got %0d want 35", lat); end
        @(posedge clk); #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL busy_ignore_no_requeue: got %b want 0", bus.busy); end
    endtask

    task automatic test_clr_abort();
        logic [63:0] z; int lat; logic dz, bok;
        bus.start = 1'b1; bus.RegA = 32'd1000; bus.RegB = 32'd3; bus.sign_mode = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);   // edge 12: tenth iteration
        #1 clr = 1'b1;
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL clr_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.Z !== 64'h0) begin n_err++; $display("FAIL clr_z: got %h want 0", bus.Z); end
        #2 clr = 1'b0;
        do_op(32'd9, 32'd2, 1'b0, z, lat, dz, bok);
        n_cmp++; if (z !== 64'h00000001_00000004) begin n_err++; $display("FAIL clr_restart_z: got %h want 0000000100000004", z); end
        n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL clr_restart_latency: got %0d want 35", lat); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] z; int lat; logic dz, bok;
        do_op(32'd100, 32'd7, 1'b0, z, lat, dz, bok);
        // done is high right now: launch the next operation in this cycle
        do_op(32'd7, 32'd2, 1'b0, z, lat, dz, bok);
        n_cmp++; if (z !== 64'h00000001_00000003) begin n_err++; $display("FAIL b2b_z: got %h want 0000000100000003", z); end
        n_cmp++; if (lat !== 35) begin n_err++; $display("FAIL b2b_latency: got %0d want 35", lat); end
        n_cmp++; if (bok !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", bok); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_boundaries();
        test_busy_ignore();
        test_clr_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
Sequential controller for the 32-bit restoring divider. It runs one shift/subtract/restore iteration per clock, so the DIV instruction does not need a 32-stage combinational chain. It adds a start/busy/done handshake, signed/unsigned modes, and divide-by-zero detection. It sits between the control unit and the HI/LO (Z) registers. Output packing matches the existing divider: Z = {remainder, quotient}.

Parameters:
WIDTH, 32, operand width; quotient and remainder are each WIDTH bits and Z is 2*WIDTH bits.

Ports:
clk  in  1  system clock; all state changes on the rising edge
clr  in  1  asynchronous, active-high reset
start  in  1  request a division; sampled only in IDLE
sign_mode  in  1  1 = two's-complement signed, 0 = unsigned; captured with start
RegA  in  WIDTH  dividend; captured with start
RegB  in  WIDTH  divisor; captured with start
busy  out  1  high while an operation is in progress (PREP, ITER, FIX)
done  out  1  one-cycle pulse when Z is valid
div_by_zero  out  1  set with done when divisor was 0; held until next accepted start
Z  out  2*WIDTH  {remainder, quotient}; holds last result

Behaviour:
- Reset, while clr is high and asynchronous to clk:
  - state = IDLE; busy = 0, done = 0, div_by_zero = 0.
  - Z = 0; all internal registers (A, Q, M, count, sign flags) = 0.
- States: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> IDLE.
- IDLE:
  - If start = 1, capture RegA, RegB and sign_mode, clear div_by_zero, go to PREP.
  - Otherwise stay. Z is unchanged.
- PREP:
  - Unsigned mode: magnitudes are the raw operands.
  - Signed mode: magnitude = two's-complement negation when bit WIDTH-1 is set.
  - Record q_neg = signA XOR signB (signed mode only) and r_neg = signA.
  - Load A = 0, Q = |dividend|, M = |divisor|, count = 0.
  - If the captured divisor is 0, go to FIX with the dz flag set. Otherwise go to ITER.
- ITER, one iteration per edge:
  - {A,Q} shifted left 1, then A = A - M.
  - If A[MSB] = 0, Q[0] = 1.
  - Else Q[0] = 0 and A = A + M (restore).
  - A is WIDTH+1 bits internally so that magnitude 2^(WIDTH-1) operands do not alias.
  - count increments; after the WIDTH-th iteration go to FIX.
- FIX:
  - Normal case: quotient = q_neg ? -Q : Q; remainder = r_neg ? -A : A (low WIDTH bits).
  - dz case: quotient = all ones; remainder = captured dividend unmodified; div_by_zero = 1.
  - Z loads {remainder, quotient}, done = 1 for the following cycle, state returns to IDLE.
- Latency, counting the start-sampling edge as edge 1:
  - Normal: done is high after edge WIDTH+3, i.e. edge 35 for WIDTH = 32.
  - dz: done is high after edge 3.
- busy: high from after the start edge until done rises. busy and done are never high together.
- done is a pulse. It drops on the next edge unless a new operation completes.
- start while busy: ignored, no queuing.
- start in the cycle done is high: accepted, since state is IDLE. Back-to-back throughput is one result per WIDTH+3 cycles.
- Signed overflow, -2^(WIDTH-1) / -1: quotient = 0x80000000, remainder = 0, no flag.
- Remainder is always smaller in magnitude than the divisor. A nonzero remainder carries the dividend's sign.
- clr mid-operation: aborts immediately, no done pulse, Z = 0. A new start is accepted on the first edge after clr deasserts.
- RegA/RegB/sign_mode changes after the start edge have no effect on the running operation.

Test Plan:
- Unsigned 100 / 7, sign_mode = 0 -> after edge 35: done = 1 for 1 cycle, Z = 0x00000002_0000000E, div_by_zero = 0; busy high on edges 2..34 only.
- Signed -100 / 7 (RegA = 0xFFFFFF9C) -> Z = 0xFFFFFFFE_FFFFFFF2 (R = -2, Q = -14). Signed 100 / -7 -> Z = 0x00000002_FFFFFFF2.
- Divide by zero, RegA = 5, RegB = 0 -> done after edge 3, div_by_zero = 1, Z = 0x00000005_FFFFFFFF. Next accepted start clears div_by_zero.
- Boundaries:
  - Signed 0x80000000 / 0xFFFFFFFF -> Z = 0x00000000_80000000.
  - Unsigned 0xFFFFFFFF / 1 -> Z = 0x00000000_FFFFFFFF.
  - Unsigned 3 / 0xFFFFFFFF -> Z = 0x00000003_00000000.
- Changing RegA and pulsing start while busy does not alter the result.
- Assert clr at iteration 10 -> busy = 0 and Z = 0 immediately, and no done follows. A fresh start of 9 / 2 then yields Z = 0x00000001_00000004.
- Raise start in the same cycle done is high: the second operation is accepted, and its done arrives exactly 35 edges later.
